ie16ba_prog_loader: RTL and testbench

Instruction encoder and program loader for the MAS16bA core: the write-side counterpart of the instruction decoder. It accepts decoded instruction fields (opcode, rd, ra, rb, c) over a valid/ready handshake and packs each into the 16-bit word format. It buffers the words in a small FIFO and writes them into instruction memory at consecutive addresses from a programmable base. It sits between the debug/boot host interface and the instruction memory write port.

---
 rtl/mas16ba_pkg.sv | 45 ++++
 rtl/ie16ba_prog_loader_if.sv | 28 ++
 rtl/ie16ba_fifo.sv | 44 ++++
 rtl/ie16ba_prog_loader.sv | 107 ++++++++++
 tb/tb_ie16ba_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mas16ba_pkg.sv
// mas16ba_pkg: MAS16bA instruction format shared by the encoder/loader and the decoder.
// Opcode values, field bit positions, immediate-select rule and the field packer.
package mas16ba_pkg;

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_MOV = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_JMP = 4'hF;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 8;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

    // Opcodes whose low byte carries the 8-bit constant instead of rb.
    function automatic logic sel_b(input logic [3:0] op);
        return op inside {OP_ADC, OP_LD, OP_ST, OP_LDI, OP_BEQ, OP_BNE, OP_JMP};
    endfunction

    function automatic logic [15:0] encode(input logic [3:0] op, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [1:0] rb,
                                           input logic [7:0] c);
        logic [15:0] w;
        w = '0;
        w[OPC_LSB +: 4] = op;
        w[RD_LSB +: 2]  = rd;
        w[RA_LSB +: 2]  = ra;
        w[7:0]          = sel_b(op) ? c : {6'b0, rb};
        return w;
    endfunction

endpackage

// File: rtl/ie16ba_prog_loader_if.sv
// ie16ba_prog_loader_if: field-bundle input handshake plus instruction-memory write port.
// master = host/memory side, slave = loader.
interface ie16ba_prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_opcode;
    logic [1:0]        in_rd;
    logic [1:0]        in_ra;
    logic [1:0]        in_rb;
    logic [7:0]        in_c;
    logic              imem_wen;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_last, in_opcode, in_rd, in_ra, in_rb, in_c, imem_ready,
        input  in_ready, imem_wen, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_rd, in_ra, in_rb, in_c, imem_ready,
        output in_ready, imem_wen, imem_addr, imem_wdata
    );
endinterface

// File: rtl/ie16ba_fifo.sv
// ie16ba_fifo: synchronous DEPTH-entry FIFO with async pointer reset and a sync clear.
// Storage is not reset; only the pointers are.
module ie16ba_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, rp_q;

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (clr) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push && !full) wp_q <= wp_q + PTR_ONE;
            if (pop && !empty) rp_q <= rp_q + PTR_ONE;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout  = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/ie16ba_prog_loader.sv
// ie16ba_prog_loader: packs MAS16bA instruction fields and writes them to imem from a base address.
// Define IE16BA_CKSUM_EN to add the cksum output (XOR of words written since the last start).
module ie16ba_prog_loader
    import mas16ba_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    ie16ba_prog_loader_if.slave bus,
    inout  wire                 dvdd,
    inout  wire                 dgnd,
    output logic                busy,
    output logic                done,
`ifdef IE16BA_CKSUM_EN
    output logic [15:0]         cksum,
`endif
    output logic                err
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              full, empty, push, pop, clr, wr, ovf;
    logic [16:0]       head;
    logic              unused_supply;

    assign unused_supply = dvdd ^ dgnd;

    // FIFO entries carry the in_last flag above the encoded word.
    ie16ba_fifo #(.DEPTH(DEPTH), .WIDTH(17)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   ({bus.in_last, encode(bus.in_opcode, bus.in_rd, bus.in_ra, bus.in_rb, bus.in_c)}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign busy           = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign bus.in_ready   = (state_q == S_LOAD) && !full;
    assign bus.imem_wen   = busy && !empty;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = bus.imem_wen ? head[15:0] : 16'h0000;

    // A non-final word landing on the top address ends the load and discards everything queued.
    assign wr   = bus.imem_wen && bus.imem_ready;
    assign ovf  = wr && (addr_q == ADDR_MAX) && !head[16];
    assign clr  = ovf;
    assign pop  = wr && !ovf;
    assign push = bus.in_valid && bus.in_ready && !ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                addr_d  = base_addr;
                err_d   = 1'b0;
            end
            S_LOAD:  if (push && bus.in_last) state_d = S_FLUSH;
            S_FLUSH: if (wr && head[16]) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (wr && (addr_q != ADDR_MAX)) addr_d = addr_q + ADDR_ONE;
        if (ovf) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
    end

`ifdef IE16BA_CKSUM_EN
    logic [15:0] cksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cksum_q <= '0;
        else if ((state_q == S_IDLE) && start) cksum_q <= '0;
        else if (wr) cksum_q <= cksum_q ^ head[15:0];
    end

    assign cksum = cksum_q;
`endif
endmodule

// File: tb/tb_ie16ba_prog_loader.sv
// tb_ie16ba_prog_loader: randomized scoreboard bench for the program loader.
// Stimulus queues expected {addr, word} writes; an independent monitor pops and compares.
module tb_ie16ba_prog_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       busy, done, err;
    wire        dvdd;
    wire        dgnd;
    assign dvdd = 1'b1;
    assign dgnd = 1'b0;
`ifdef IE16BA_CKSUM_EN
    logic [15:0] cksum;
`endif

    ie16ba_prog_loader_if #(.ADDR_W(8)) bus ();

    ie16ba_prog_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .dvdd      (dvdd),
        .dgnd      (dgnd),
        .busy      (busy),
        .done      (done),
`ifdef IE16BA_CKSUM_EN
        .cksum     (cksum),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_addr;
    logic [15:0] cks_exp;
    bit          err_exp;
    bit          hold_low = 1'b0;
    int          rdy_pct = 100;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference encoder: low byte is c for opcodes in mask 0xE701, else rb.
    function automatic logic [15:0] model_word(input int op, input int rd, input int ra,
                                               input int rb, input int c);
        int selb_mask;
        int low;
        selb_mask = 'hE701;
        low = (((selb_mask >> op) & 1) != 0) ? c : rb;
        return 16'(op * 4096 + rd * 1024 + ra * 256 + low);
    endfunction

    initial begin
        bus.imem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_ready = hold_low ? 1'b0 : ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: every completed write must match the head of the scoreboard; stalled writes must hold.
    initial begin
        bit          prev_stall;
        logic [7:0]  prev_addr;
        logic [15:0] prev_data;
        exp_t        e;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_wen", bus.imem_wen, 1);
                    chk("stall_hold_addr", bus.imem_addr, prev_addr);
                    chk("stall_hold_data", bus.imem_wdata, prev_data);
                end
                if (bus.imem_wen && bus.imem_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h @%0h, required no write",
                                 bus.imem_wdata, bus.imem_addr);
                    end else begin
                        e = sbq.pop_front();
                        chk("wr_addr", bus.imem_addr, e.addr);
                        chk("wr_data", bus.imem_wdata, e.data);
                    end
                end
                prev_stall = bus.imem_wen && !bus.imem_ready;
                prev_addr  = bus.imem_addr;
                prev_data  = bus.imem_wdata;
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_start(input logic [7:0] b);
        cur_addr  = b;
        cks_exp   = '0;
        err_exp   = 1'b0;
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_in_ready", bus.in_ready, 1);
        chk("start_err_clr", err, 0);
`ifdef IE16BA_CKSUM_EN
        chk("start_cksum_clr", cksum, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] c, input logic last,
                         input logic [15:0] exp_word);
        int t;
        bit acc;
        bit must;
        t    = 0;
        acc  = 1'b0;
        must = (cur_addr <= 255);
        if (must) begin
            sbq.push_back('{addr: 8'(cur_addr), data: exp_word});
            cks_exp = cks_exp ^ exp_word;
            cur_addr++;
        end else begin
            err_exp = 1'b1;
        end
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_ra     = ra;
        bus.in_rb     = rb;
        bus.in_c      = c;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        while (!acc && t < (must ? 40 : 3)) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (must) chk("accept", acc, 1);
    endtask

    task automatic issue_rand(input logic last);
        int op, rd, ra, rb, c;
        op = $urandom_range(15);
        rd = $urandom_range(3);
        ra = $urandom_range(3);
        rb = $urandom_range(3);
        c  = $urandom_range(255);
        issue(4'(op), 2'(rd), 2'(ra), 2'(rb), 8'(c), last, model_word(op, rd, ra, rb, c));
    endtask

    task automatic wait_done();
        int t;
        bit seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 300) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            t++;
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("done_busy", busy, 0);
            chk("done_err", err, err_exp);
            chk("sb_drained", sbq.size(), 0);
`ifdef IE16BA_CKSUM_EN
            chk("done_cksum", cksum, cks_exp);
`endif
            @(negedge clk);
            chk("done_width", done, 0);
        end
        sbq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.in_ra     = '0;
        bus.in_rb     = '0;
        bus.in_c      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wen", bus.imem_wen, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD r1,r2,r3 with unused c, single-word program
        do_start(8'h10);
        issue(4'h1, 2'd1, 2'd2, 2'd3, 8'hFF, 1'b1, 16'h1603);
        wait_done();

        // LD r0,r1,#0x2A then JMP #0x40
        do_start(8'h20);
        issue(4'h8, 2'd0, 2'd1, 2'd3, 8'h2A, 1'b0, 16'h812A);
        issue(4'hF, 2'd0, 2'd0, 2'd0, 8'h40, 1'b1, 16'hF040);
        wait_done();

        // Memory stalled: four words fill the FIFO, then in_ready must drop
        hold_low = 1'b1;
        do_start(8'h30);
        for (int i = 0; i < 4; i++) issue_rand(1'b0);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_wen", bus.imem_wen, 1);
        @(posedge clk);
        #1 hold_low = 1'b0;
        issue_rand(1'b0);
        issue_rand(1'b1);
        wait_done();

        // Overflow: third word would go past 0xFF
        do_start(8'hFE);
        issue_rand(1'b0);
        issue_rand(1'b0);
        issue_rand(1'b1);
        wait_done();

        // Last word exactly at 0xFF is legal; start also clears err
        do_start(8'hFF);
        issue_rand(1'b1);
        wait_done();

        // Async reset mid-load with words queued
        hold_low = 1'b1;
        do_start(8'h40);
        issue_rand(1'b0);
        issue_rand(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_wen", bus.imem_wen, 0);
        chk("arst_addr", bus.imem_addr, 0);
        chk("arst_wdata", bus.imem_wdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        sbq.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        hold_low = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_wen", bus.imem_wen, 0);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Randomized programs under random memory backpressure
        for (int p = 0; p < 10; p++) begin
            int n;
            n       = $urandom_range(1, 9);
            rdy_pct = $urandom_range(30, 100);
            do_start(8'($urandom_range(0, 255 - n)));
            for (int k = 0; k < n; k++) issue_rand(k == n - 1);
            wait_done();
        end
        rdy_pct = 100;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
